// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter granting two requesters access to one
//               shared external ALU. The granted operation is held on the ALU
//               for SETTLE_CYCLES cycles, the result is captured, and it is
//               returned through a valid/ready response port. Unsupported op
//               codes bypass the ALU and return an error response.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [3:0]  alu_control,
    output logic [31:0] input1,
    output logic [31:0] input2,
    input  logic [31:0] alu_result,
    input  logic        zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter value on the last EXEC cycle.
    localparam logic [3:0] C_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic        prio_q, prio_d;      // requester that wins a tie
    logic [3:0]  cnt_q, cnt_d;        // EXEC settle counter
    logic        id_q, id_d;
    logic [3:0]  ctl_q, ctl_d;
    logic [31:0] in1_q, in1_d;
    logic [31:0] in2_q, in2_d;
    logic [31:0] res_q, res_d;
    logic        zero_q, zero_d;
    logic        err_q, err_d;

    logic        grant_valid;
    logic        grant_id;
    logic [3:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic        op_ok;

    // Grant selection, op decode and next-state / output logic.
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        ctl_d      = ctl_q;
        in1_d      = in1_q;
        in2_d      = in2_q;
        res_d      = res_q;
        zero_d     = zero_q;
        err_d      = err_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        grant_valid = req0_valid | req1_valid;
        grant_id    = (req0_valid && req1_valid) ? prio_q : ~req0_valid;
        sel_op      = grant_id ? req1_op : req0_op;
        sel_a       = grant_id ? req1_a  : req0_a;
        sel_b       = grant_id ? req1_b  : req0_b;

        case (sel_op)
            4'b0010, 4'b0110, 4'b0000,
            4'b0001, 4'b1100, 4'b1001: op_ok = 1'b1;
            default:                   op_ok = 1'b0;
        endcase

        case (state_q)
            IDLE: begin
                if (grant_valid && !reset) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    id_d       = grant_id;
                    prio_d     = ~grant_id;
                    if (op_ok) begin
                        // Only legal ops ever reach the ALU pins.
                        ctl_d   = sel_op;
                        in1_d   = sel_a;
                        in2_d   = sel_b;
                        cnt_d   = 4'd0;
                        state_d = EXEC;
                    end else begin
                        res_d   = 32'd0;
                        zero_d  = 1'b0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == C_SETTLE_LAST) begin
                    res_d   = alu_result;
                    zero_d  = zero;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= 4'd0;
            id_q    <= 1'b0;
            ctl_q   <= 4'd0;
            in1_q   <= 32'd0;
            in2_q   <= 32'd0;
            res_q   <= 32'd0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            ctl_q   <= ctl_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign alu_control = ctl_q;
    assign input1      = in1_q;
    assign input2      = in2_q;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_id      = id_q;
    assign rsp_result  = res_q;
    assign rsp_zero    = zero_q;
    assign rsp_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. Three instances with
//               SETTLE_CYCLES 1, 3 and 4 share the stimulus; one is selected
//               for checking per scenario. A behavioural ALU answers each
//               instance. Expected responses go into a scoreboard queue that
//               a monitor process drains on each response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int NDUT = 3;

    function automatic int s_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    // Shared ALU: sll shifts input2 left by input1.
    function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] x,
                                          input logic [31:0] y);
        case (c)
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b1100: return ~(x | y);
            4'b1001: return y << x[4:0];
            default: return 32'd0;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, rsp_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;

    logic [NDUT-1:0] r0_rdy, r1_rdy, v, rid, rz, rerr, azero;
    logic [31:0]     rres [NDUT];
    logic [3:0]      actl [NDUT];
    logic [31:0]     ain1 [NDUT];
    logic [31:0]     ain2 [NDUT];
    logic [31:0]     ares [NDUT];

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        assign ares[k]  = alu_f(actl[k], ain1[k], ain2[k]);
        assign azero[k] = (ares[k] == 32'd0);
        alu_arbiter #(.SETTLE_CYCLES(s_of(k))) u_dut (
            .clk        (clk),
            .reset      (reset),
            .req0_valid (req0_valid),
            .req0_ready (r0_rdy[k]),
            .req0_op    (req0_op),
            .req0_a     (req0_a),
            .req0_b     (req0_b),
            .req1_valid (req1_valid),
            .req1_ready (r1_rdy[k]),
            .req1_op    (req1_op),
            .req1_a     (req1_a),
            .req1_b     (req1_b),
            .alu_control(actl[k]),
            .input1     (ain1[k]),
            .input2     (ain2[k]),
            .alu_result (ares[k]),
            .zero       (azero[k]),
            .rsp_valid  (v[k]),
            .rsp_ready  (rsp_ready),
            .rsp_id     (rid[k]),
            .rsp_result (rres[k]),
            .rsp_zero   (rz[k]),
            .rsp_err    (rerr[k])
        );
    end

    initial forever #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        zero;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   sel = 0;
    logic watch_ill = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_grant(output int who, output int tcyc);
        who = -1;
        tcyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (r0_rdy[sel] || r1_rdy[sel]) begin
                chk("single_ready", 64'(r0_rdy[sel] & r1_rdy[sel]), 64'(0));
                who = r1_rdy[sel] ? 1 : 0;
                tcyc = cyc;
                break;
            end
        end
        if (who < 0) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout: no ready within 40 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic push(input int id, input logic [31:0] res, input logic z, input logic err,
                        input int tcyc);
        exp_t e;
        if (tcyc >= 0) begin
            e.id   = id[0];
            e.res  = res;
            e.zero = z;
            e.err  = err;
            e.cyc  = tcyc + (err ? 1 : 1 + s_of(sel));
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d responses missing (cycle %0d)", sb.size(), cyc);
            sb.delete();
        end
        tick();
    endtask

    // Monitor: checks latency on the rising edge of rsp_valid, stability while
    // it is held, and the response fields on each handshake.
    initial begin : monitor
        exp_t        e;
        logic [34:0] hold;
        logic        prev_v;
        prev_v = 1'b0;
        hold   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_v = 1'b0;
            end else begin
                if (watch_ill)
                    chk("alu_ctl_never_illegal", 64'(actl[sel] == 4'b0111), 64'(0));
                if (v[sel]) begin
                    if (!prev_v) begin
                        hold = {rid[sel], rres[sel], rz[sel], rerr[sel]};
                        if (sb.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding (cycle %0d)", cyc);
                        end else begin
                            e = sb[0];
                            chk("rsp_latency", 64'(cyc), 64'(e.cyc));
                        end
                    end else begin
                        chk("rsp_stable", 64'({rid[sel], rres[sel], rz[sel], rerr[sel]}), 64'(hold));
                    end
                    if (rsp_ready && sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("rsp_id", 64'(rid[sel]), 64'(e.id));
                        chk("rsp_result", 64'(rres[sel]), 64'(e.res));
                        chk("rsp_zero", 64'(rz[sel]), 64'(e.zero));
                        chk("rsp_err", 64'(rerr[sel]), 64'(e.err));
                    end
                end
                prev_v = v[sel] && !rsp_ready;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int who, t, prev, h;
        reset = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
        req1_op = 4'd0; req1_a = 32'd0; req1_b = 32'd0;

        // Reset state; requests present during reset must not see ready.
        sel = 0;
        req0_op = 4'b0010; req1_op = 4'b0010;
        req0_valid = 1'b1; req1_valid = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_ready", 64'({r0_rdy[sel], r1_rdy[sel]}), 64'(0));
        chk("rst_rsp_flags", 64'({v[sel], rid[sel], rz[sel], rerr[sel]}), 64'(0));
        chk("rst_rsp_result", 64'(rres[sel]), 64'(0));
        chk("rst_alu_ctl", 64'(actl[sel]), 64'(0));
        chk("rst_input1", 64'(ain1[sel]), 64'(0));
        chk("rst_input2", 64'(ain2[sel]), 64'(0));

        // Single add, SETTLE_CYCLES=1.
        do_reset();
        rsp_ready = 1'b1;
        req0_op = 4'b0010; req0_a = 32'd5; req0_b = 32'd7; req0_valid = 1'b1;
        wait_grant(who, t);
        chk("add_grant", 64'(who), 64'(0));
        push(0, 32'd12, 1'b0, 1'b0, t);
        tick();
        req0_valid = 1'b0;
        drain();

        // Contention: grants alternate, one accept every SETTLE_CYCLES+2.
        do_reset();
        rsp_ready = 1'b1;
        req0_op = 4'b0110; req0_a = 32'd3; req0_b = 32'd3;
        req1_op = 4'b0001; req1_a = 32'd1; req1_b = 32'd2;
        req0_valid = 1'b1; req1_valid = 1'b1;
        prev = -1;
        for (int g = 0; g < 4; g++) begin
            wait_grant(who, t);
            chk("rr_order", 64'(who), 64'(g % 2));
            if (prev >= 0) chk("rr_spacing", 64'(t - prev), 64'(3));
            if (who == 1) push(1, 32'd3, 1'b0, 1'b0, t);
            else          push(0, 32'd0, 1'b1, 1'b0, t);
            prev = t;
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // Backpressure: response held, req1 waits until after the handshake.
        do_reset();
        req0_op = 4'b0010; req0_a = 32'd1; req0_b = 32'd1;
        req1_op = 4'b0001; req1_a = 32'd1; req1_b = 32'd2;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_grant(who, t);
        chk("bp_first_grant", 64'(who), 64'(0));
        push(0, 32'd2, 1'b0, 1'b0, t);
        tick();
        req0_valid = 1'b0;
        for (int i = 0; i < 10 && !v[sel]; i++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("bp_ready_low", 64'({r0_rdy[sel], r1_rdy[sel]}), 64'(0));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        h = cyc;
        wait_grant(who, t);
        chk("bp_second_grant", 64'(who), 64'(1));
        chk("bp_grant_cycle", 64'(t), 64'(h + 1));
        push(1, 32'd3, 1'b0, 1'b0, t);
        tick();
        req1_valid = 1'b0;
        drain();

        // Unsupported op: immediate error response, ALU untouched.
        do_reset();
        rsp_ready = 1'b1;
        watch_ill = 1'b1;
        req1_op = 4'b0111; req1_a = 32'd1; req1_b = 32'd2; req1_valid = 1'b1;
        wait_grant(who, t);
        chk("ill_grant", 64'(who), 64'(1));
        push(1, 32'd0, 1'b0, 1'b1, t);
        tick();
        req1_valid = 1'b0;
        drain();
        watch_ill = 1'b0;

        // Shift with SETTLE_CYCLES=3: operands held three cycles.
        sel = 1;
        do_reset();
        rsp_ready = 1'b1;
        req0_op = 4'b1001; req0_a = 32'd4; req0_b = 32'd1; req0_valid = 1'b1;
        wait_grant(who, t);
        chk("sll_grant", 64'(who), 64'(0));
        push(0, 32'd16, 1'b0, 1'b0, t);
        tick();
        req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("sll_ctl", 64'(actl[sel]), 64'(4'b1001));
            chk("sll_operands", 64'({ain1[sel], ain2[sel]}), {32'd4, 32'd1});
        end
        drain();

        // Reset on the 2nd EXEC cycle with SETTLE_CYCLES=4.
        sel = 2;
        do_reset();
        rsp_ready = 1'b1;
        req0_op = 4'b0010; req0_a = 32'd9; req0_b = 32'd6; req0_valid = 1'b1;
        wait_grant(who, t);
        push(0, 32'd15, 1'b0, 1'b0, t);
        tick();
        req0_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_rsp", 64'({v[sel], rid[sel], rz[sel], rerr[sel]}), 64'(0));
        chk("mid_rst_result", 64'(rres[sel]), 64'(0));
        chk("mid_rst_alu", 64'({actl[sel], ain1[sel]}), 64'(0));
        chk("mid_rst_input2", 64'(ain2[sel]), 64'(0));
        repeat (8) tick();
        req1_op = 4'b0010; req1_a = 32'd1; req1_b = 32'd1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_grant(who, t);
        chk("mid_rst_tie", 64'(who), 64'(0));
        push(0, 32'd15, 1'b0, 1'b0, t);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning the number of cycles (1..15) the operands are held on the ALU before the result is captured.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester n has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  operation of requester n accepted this cycle.
REQ-006 SHALL have ports req0_op / req1_op  input  4  ALU control code of requester n.
REQ-007 SHALL have ports req0_a, req0_b / req1_a, req1_b  input  32  operands of requester n.
REQ-008 SHALL have ports alu_control  output  4, input1 and input2  output  32, which drive the shared ALU.
REQ-009 SHALL have ports alu_result  input  32 and zero  input  1, which are returned by the shared ALU.
REQ-010 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  1 (granted requester), rsp_result  output  32, rsp_zero  output  1, rsp_err  output  1.

Function
REQ-011 SHALL implement the FSM states IDLE, EXEC and RESP.
REQ-012 In IDLE with at least one valid request, SHALL grant one requester, assert only that requester's ready combinationally in the same cycle, latch its op, a, b and id, and leave IDLE on the next edge.
REQ-013 Arbitration SHALL be round-robin: with both valid, the requester not granted last wins; after reset, requester 0 wins a tie.
REQ-014 The priority pointer SHALL update only on a grant.
REQ-015 ready SHALL be 0 in EXEC and RESP, and 0 in IDLE for the non-granted requester.
REQ-016 Supported op codes SHALL be 0010 add, 0110 sub, 0000 and, 0001 or, 1100 nor and 1001 sll.
REQ-017 A supported op SHALL go from IDLE to EXEC; an unsupported op SHALL go from IDLE directly to RESP with rsp_err=1, rsp_result=0 and rsp_zero=0, and SHALL never be driven onto the ALU.
REQ-018 In EXEC, alu_control, input1 and input2 SHALL equal the latched op, a and b, held stable for exactly SETTLE_CYCLES cycles.
REQ-019 On the final EXEC cycle, SHALL register alu_result into rsp_result and zero into rsp_zero, set rsp_err=0, and enter RESP.
REQ-020 Outside EXEC, alu_control, input1 and input2 SHALL keep their last driven values (0 after reset).
REQ-021 rsp_valid SHALL be 1 exactly while in RESP.
REQ-022 rsp_id, rsp_result, rsp_zero and rsp_err SHALL be stable while rsp_valid=1.
REQ-023 In RESP, rsp_valid&rsp_ready SHALL return the FSM to IDLE on the next edge; without rsp_ready, the FSM SHALL stay in RESP indefinitely.
REQ-024 Latency SHALL be: accept at cycle T, rsp_valid first high at T+1+SETTLE_CYCLES for a supported op and at T+1 for an unsupported op.
REQ-025 Throughput SHALL be at most one accept per SETTLE_CYCLES+2 cycles; no new grant is allowed before the response handshake completes.
REQ-026 If rsp_ready=1 on the first RESP cycle, the next grant SHALL occur in the following cycle (IDLE).
REQ-027 Requests SHALL not be queued: a requester dropping valid before ready loses nothing, and the block holds no state for it.
REQ-028 The EXEC settle counter SHALL be 4 bits and SHALL reset to 0 on each entry to EXEC.

Reset
REQ-029 reset=1 at a clock edge SHALL force, from any state including mid-EXEC or RESP: state=IDLE; rsp_valid, rsp_id, rsp_result, rsp_zero and rsp_err=0; alu_control=0; input1 and input2=0; settle counter=0; priority to requester 0.
REQ-030 While reset=1, both ready outputs SHALL be 0.
REQ-031 Any in-flight operation SHALL be discarded without a response.

Verification
REQ-032 Single add: SETTLE_CYCLES=1, req0 op=0010, a=5, b=7, rsp_ready=1 -> req0_ready at T; rsp_valid at T+2 with rsp_id=0, rsp_result=12, rsp_zero=0, rsp_err=0.
REQ-033 Contention: both valid continuously, req0 sub 3-3, req1 or 1|2 -> grants alternate 0,1,0,1; req0 responses rsp_result=0, rsp_zero=1; req1 responses rsp_result=3, rsp_zero=0.
REQ-034 Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp fields constant, both ready=0, req1_valid=1 not granted until the cycle after the handshake.
REQ-035 Illegal op: req1 op=0111 -> rsp_valid at T+1 with rsp_err=1, rsp_result=0, rsp_zero=0; alu_control never equals 0111.
REQ-036 Reset mid-EXEC: SETTLE_CYCLES=4, reset asserted on the 2nd EXEC cycle -> next cycle state IDLE with all outputs 0, no response issued, and a subsequent tie granted to req0.
REQ-037 Shift with settle: SETTLE_CYCLES=3, op=1001, a=4, b=1 -> operands stable for 3 cycles; rsp_result=16 at T+4.
